id_ex_pipe: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 16-bit, 16-register five-stage pipeline. It captures decoded operands, register IDs and control from ID, and presents them to EX and the forwarding unit. It inserts a bubble and stalls IF/ID when a load in EX feeds the instruction in ID. It also holds on downstream stalls and squashes on branch flush.

---
 rtl/wisc_pkg.sv | 41 ++++
 rtl/idex_hazard_detect.sv | 22 ++
 rtl/id_ex_pipe.sv | 86 ++++++++
 tb/tb_id_ex_pipe.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared widths, opcodes, control-field indices and the ID/EX payload type.
package wisc_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 4;
  localparam int CTRL_W = 7;
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_MEM_READ = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC = 2;
  localparam int CTRL_PCS = 1;
  localparam int CTRL_HALT = 0;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW = 4'h8;
  localparam logic [3:0] OP_SW = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_B = 4'hC;
  localparam logic [3:0] OP_BR = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc_plus2;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;
endpackage

// File: rtl/idex_hazard_detect.sv
// idex_hazard_detect: load-use hazard between the load in EX and the instruction in ID.
module idex_hazard_detect
  import wisc_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mem_write,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hz
);
  logic rs_hit, rt_hit;
  assign rs_hit = id_uses_rs && (ex_rd == id_rs);
  assign rt_hit = id_uses_rt && (ex_rd == id_rt);
  // a store needing the load result only as its data gets it by MEM-to-MEM forwarding
  assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
              && (rs_hit || (rt_hit && !id_mem_write));
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX register with load-use bubble insertion, hold and flush.
// IDEX_PERF_CNT_EN adds saturating stall/flush counters; otherwise they read 0.
module id_ex_pipe
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_plus2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);
  idex_t q, cap, nxt;
  logic hz;
  idex_hazard_detect u_hz (
    .ex_valid    (q.valid),
    .ex_mem_read (q.ctrl[CTRL_MEM_READ]),
    .ex_rd       (q.rd),
    .id_valid    (id_valid),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_mem_write(id_ctrl[CTRL_MEM_WRITE]),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hz          (hz)
  );
  assign stall_o = hz && !flush && !hold;
  always_comb begin
    cap = '{valid: id_valid, opcode: id_opcode, rs: id_rs, rt: id_rt, rd: id_rd,
            rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
            pc_plus2: id_pc_plus2, ctrl: id_valid ? id_ctrl : '0};
    nxt = (flush || (hz && !hold)) ? '0 : hold ? q : cap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= nxt;
  assign ex_valid    = q.valid;
  assign ex_opcode   = q.opcode;
  assign ex_rs       = q.rs;
  assign ex_rt       = q.rt;
  assign ex_rd       = q.rd;
  assign ex_rs_data  = q.rs_data;
  assign ex_rt_data  = q.rt_data;
  assign ex_imm      = q.imm;
  assign ex_pc_plus2 = q.pc_plus2;
  assign ex_ctrl     = q.ctrl;
`ifdef IDEX_PERF_CNT_EN
  logic [15:0] s_cnt, f_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_cnt <= '0;
      f_cnt <= '0;
    end else begin
      if (stall_o && s_cnt != 16'hFFFF) s_cnt <= s_cnt + 16'd1;
      if (flush && f_cnt != 16'hFFFF) f_cnt <= f_cnt + 16'd1;
    end
  assign stall_cnt = s_cnt;
  assign flush_cnt = f_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed scenarios for the ID/EX register and load-use detection.
module tb_id_ex_pipe;
  import wisc_pkg::*;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_uses_rs, id_uses_rt, flush, hold;
  logic [3:0] id_opcode;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc_plus2;
  logic [CTRL_W-1:0] id_ctrl;
  logic stall_o, ex_valid;
  logic [3:0] ex_opcode;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus2;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [15:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  localparam logic [6:0] C_LW = 7'b1101100;
  localparam logic [6:0] C_ADD = 7'b1000000;
  localparam logic [6:0] C_SW = 7'b0010100;
`ifdef IDEX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc_plus2(id_pc_plus2), .id_ctrl(id_ctrl), .flush(flush),
    .hold(hold), .stall_o(stall_o), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc_plus2(ex_pc_plus2),
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic drv(input logic v, input logic [3:0] op, input logic [3:0] rs, rt, rd,
                     input logic urs, urt, input logic [15:0] rsd, rtd, imm,
                     input logic [6:0] ctrl);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_pc_plus2 = imm + 16'd2; id_ctrl = ctrl;
    #1;
  endtask
  task automatic test_reset;
    flush = 0; hold = 0;
    drv(1, OP_ADD, 1, 2, 3, 1, 1, 16'h1, 16'h2, 16'h3, C_ADD);
    tick;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    total++; if (ex_ctrl !== 7'd0 || ex_rd !== 4'd0 || ex_imm !== 16'd0) begin bad++; $display("FAIL reset_fields ctrl=%h rd=%h imm=%h exp=0", ex_ctrl, ex_rd, ex_imm); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt s=%0d f=%0d exp=0", stall_cnt, flush_cnt); end
    rst_n = 1;
  endtask
  task automatic test_load_use_rs;
    drv(1, OP_LW, 6, 0, 3, 1, 0, 16'h0040, 16'h0, 16'h0004, C_LW);
    tick;
    total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_LW || ex_rd !== 4'd3 || ex_pc_plus2 !== 16'h0006) begin bad++; $display("FAIL lw_capture v=%b ctrl=%h rd=%h pc=%h exp 1/%h/3/0006", ex_valid, ex_ctrl, ex_rd, ex_pc_plus2, C_LW); end
    drv(1, OP_ADD, 3, 4, 7, 1, 1, 16'hAAAA, 16'h5555, 16'h0, C_ADD);
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_rs_stall got=%b exp=1", stall_o); end
    tick;
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_rs !== 4'd0 || ex_rd !== 4'd0) begin bad++; $display("FAIL lu_bubble v=%b ctrl=%h rs=%h rd=%h exp 0", ex_valid, ex_ctrl, ex_rs, ex_rd); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%b exp=0", stall_o); end
    tick;
    total++; if (ex_valid !== 1'b1 || ex_rs !== 4'd3 || ex_rt !== 4'd4 || ex_rs_data !== 16'hAAAA || ex_ctrl !== C_ADD) begin bad++; $display("FAIL lu_add_capture v=%b rs=%h rt=%h rsd=%h ctrl=%h", ex_valid, ex_rs, ex_rt, ex_rs_data, ex_ctrl); end
    total++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0)) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 1 : 0); end
  endtask
  task automatic test_store_exempt;
    drv(1, OP_LW, 1, 0, 5, 1, 0, 16'h0, 16'h0, 16'h0, C_LW);
    tick;
    drv(1, OP_SW, 2, 5, 0, 1, 1, 16'h0100, 16'h1234, 16'h0008, C_SW);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL sw_rt_stall got=%b exp=0", stall_o); end
    tick;
    total++; if (ex_valid !== 1'b1 || ex_opcode !== OP_SW || ex_rt !== 4'd5 || ex_rt_data !== 16'h1234 || ex_ctrl !== C_SW) begin bad++; $display("FAIL sw_capture v=%b op=%h rt=%h rtd=%h ctrl=%h", ex_valid, ex_opcode, ex_rt, ex_rt_data, ex_ctrl); end
    drv(1, OP_LW, 1, 0, 5, 1, 0, 16'h0, 16'h0, 16'h0, C_LW);
    tick;
    drv(1, OP_SW, 5, 5, 0, 1, 1, 16'h0100, 16'h1234, 16'h0008, C_SW);
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL sw_rs_stall got=%b exp=1", stall_o); end
    drv(1, OP_ADD, 2, 5, 6, 1, 1, 16'h0, 16'h0, 16'h0, C_ADD);
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL add_rt_stall got=%b exp=1", stall_o); end
    tick;
  endtask
  task automatic test_r0;
    drv(1, OP_LW, 1, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0, C_LW);
    tick;
    drv(1, OP_ADD, 0, 0, 2, 1, 1, 16'h0, 16'h0, 16'h0, C_ADD);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall_o); end
    drv(0, OP_ADD, 0, 0, 9, 0, 0, 16'h0, 16'h0, 16'h0, C_LW);
    tick;
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_rd !== 4'd9) begin bad++; $display("FAIL invalid_capture v=%b ctrl=%h rd=%h exp 0/00/9", ex_valid, ex_ctrl, ex_rd); end
  endtask
  task automatic test_hold;
    drv(1, OP_LW, 2, 0, 7, 1, 0, 16'h0, 16'h0, 16'h0070, C_LW);
    tick;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drv(1, OP_ADD, 7, 4'(i), 4'(i + 1), 1, 1, 16'(i * 3), 16'(i), 16'(i + 9), C_ADD);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL hold_stall[%0d] got=%b exp=0", i, stall_o); end
      tick;
      total++; if (ex_valid !== 1'b1 || ex_opcode !== OP_LW || ex_rd !== 4'd7 || ex_imm !== 16'h0070 || ex_ctrl !== C_LW) begin bad++; $display("FAIL hold_keep[%0d] v=%b op=%h rd=%h imm=%h ctrl=%h", i, ex_valid, ex_opcode, ex_rd, ex_imm, ex_ctrl); end
    end
    hold = 0;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL hold_release_stall got=%b exp=1", stall_o); end
    tick;
    total++; if (stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin bad++; $display("FAIL hold_stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 3 : 0); end
  endtask
  task automatic test_flush;
    drv(1, OP_LW, 2, 0, 7, 1, 0, 16'h0, 16'h0, 16'h0, C_LW);
    tick;
    drv(1, OP_ADD, 7, 1, 3, 1, 1, 16'h0, 16'h0, 16'h0, C_ADD);
    flush = 1; hold = 1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    tick;
    flush = 0; hold = 0;
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_rs !== 4'd0) begin bad++; $display("FAIL flush_bubble v=%b ctrl=%h rs=%h exp 0", ex_valid, ex_ctrl, ex_rs); end
    total++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0) || stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin bad++; $display("FAIL flush_cnts f=%0d s=%0d exp f=%0d s=%0d", flush_cnt, stall_cnt, PERF ? 1 : 0, PERF ? 3 : 0); end
  endtask
  task automatic test_async_reset;
    drv(1, OP_ADD, 1, 2, 3, 1, 1, 16'h1, 16'h2, 16'h3, C_ADD);
    tick;
    total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD) begin bad++; $display("FAIL pre_reset v=%b ctrl=%h exp 1/%h", ex_valid, ex_ctrl, C_ADD); end
    rst_n = 0;
    #1;
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_rd !== 4'd0) begin bad++; $display("FAIL async_reset v=%b ctrl=%h rd=%h exp 0", ex_valid, ex_ctrl, ex_rd); end
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL async_reset_cnt s=%0d f=%0d exp 0", stall_cnt, flush_cnt); end
    tick;
    rst_n = 1;
  endtask
  initial begin
    test_reset;
    test_load_use_rs;
    test_store_exempt;
    test_r0;
    test_hold;
    test_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
